// File: rtl/frame_sel_if.sv
// Frame-select control bundle: slow control inputs from the front panel and the
// frame index/address outputs towards the capture-buffer read side.
interface frame_sel_if #(
   parameter int FRAME_W = 4,
   parameter int ADDR_W  = 14
);
   logic               frame_clk;
   logic               run_en;
   logic               step_btn;
   logic               dir;
   logic [FRAME_W-1:0] frame_idx;
   logic [ADDR_W-1:0]  frame_base_addr;
   logic               frame_tick;
   logic               paused;

   modport master (
      output frame_clk, run_en, step_btn, dir,
      input  frame_idx, frame_base_addr, frame_tick, paused
   );

   modport slave (
      input  frame_clk, run_en, step_btn, dir,
      output frame_idx, frame_base_addr, frame_tick, paused
   );
endinterface

// File: rtl/frame_sel_ctrl.sv
// Steps a display frame index from the 2 Hz frame clock (RUN) or from a debounced
// step button (PAUSED); i_rst is asynchronous and active-low.
module frame_sel_ctrl #(
   parameter int NUM_FRAMES   = 16,
   parameter int FRAME_W      = 4,
   parameter int FRAME_LEN    = 640,
   parameter int ADDR_W       = 14,
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic        i_clk_in,
   input  logic        i_rst,
   frame_sel_if.slave  bus
);

   typedef enum logic {
      ST_PAUSED = 1'b0,
      ST_RUN    = 1'b1
   } state_t;

   localparam int                 CNT_W        = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0]   LP_DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [FRAME_W-1:0] LP_LAST_IDX  = FRAME_W'(NUM_FRAMES - 1);
   localparam logic [ADDR_W-1:0]  LP_STRIDE    = ADDR_W'(FRAME_LEN);
   localparam logic [ADDR_W-1:0]  LP_LAST_ADDR = ADDR_W'((NUM_FRAMES - 1) * FRAME_LEN);

   logic               r_frame_s1, r_frame_s2, r_frame_prev;
   logic               r_run_s1, r_run_s2;
   logic               r_btn_s1, r_btn_s2;
   logic               r_btn_db, r_btn_db_d;
   logic [CNT_W-1:0]   r_db_cnt;
   logic [1:0]         r_arm;
   state_t             r_state;
   logic [FRAME_W-1:0] r_idx;
   logic [ADDR_W-1:0]  r_base;
   logic               r_tick;
   logic               r_paused;

   logic               w_fe;
   logic               w_step_req;
   logic               w_advance;
   logic [FRAME_W-1:0] w_idx_nxt;
   logic [ADDR_W-1:0]  w_base_nxt;

   // Edge mask opens one cycle after arm==2: sync chain plus edge register is three
   // stages deep, so a frame_clk already high at reset release never looks like an edge.
   always_comb begin
      w_fe       = r_frame_s2 & ~r_frame_prev & (r_arm == 2'd3);
      w_step_req = r_btn_db & ~r_btn_db_d;
      case (r_state)
         ST_RUN:    w_advance = w_fe;
         ST_PAUSED: w_advance = w_step_req;
         default:   w_advance = 1'b0;
      endcase
      if (bus.dir == 1'b0) begin
         if (r_idx == LP_LAST_IDX) begin
            w_idx_nxt  = '0;
            w_base_nxt = '0;
         end else begin
            w_idx_nxt  = r_idx + FRAME_W'(1);
            w_base_nxt = r_base + LP_STRIDE;
         end
      end else begin
         if (r_idx == '0) begin
            w_idx_nxt  = LP_LAST_IDX;
            w_base_nxt = LP_LAST_ADDR;
         end else begin
            w_idx_nxt  = r_idx - FRAME_W'(1);
            w_base_nxt = r_base - LP_STRIDE;
         end
      end
   end

   // Input synchronisers, frame edge history and post-reset arm counter.
   always_ff @(posedge i_clk_in or negedge i_rst) begin
      if (!i_rst) begin
         r_frame_s1   <= 1'b0;
         r_frame_s2   <= 1'b0;
         r_frame_prev <= 1'b0;
         r_run_s1     <= 1'b0;
         r_run_s2     <= 1'b0;
         r_btn_s1     <= 1'b0;
         r_btn_s2     <= 1'b0;
         r_arm        <= 2'd0;
      end else begin
         r_frame_s1   <= bus.frame_clk;
         r_frame_s2   <= r_frame_s1;
         r_frame_prev <= r_frame_s2;
         r_run_s1     <= bus.run_en;
         r_run_s2     <= r_run_s1;
         r_btn_s1     <= bus.step_btn;
         r_btn_s2     <= r_btn_s1;
         if (r_arm != 2'd3) begin
            r_arm <= r_arm + 2'd1;
         end else begin
            r_arm <= r_arm;
         end
      end
   end

   // Step button debounce: accept a new level after DEBOUNCE_CYC consecutive differing cycles.
   always_ff @(posedge i_clk_in or negedge i_rst) begin
      if (!i_rst) begin
         r_btn_db   <= 1'b0;
         r_btn_db_d <= 1'b0;
         r_db_cnt   <= '0;
      end else begin
         r_btn_db_d <= r_btn_db;
         if (r_btn_s2 == r_btn_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == LP_DB_LAST) begin
            r_btn_db <= r_btn_s2;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + CNT_W'(1);
         end
      end
   end

   // Mode FSM with paused decoded alongside the state, plus index/address stepping.
   always_ff @(posedge i_clk_in or negedge i_rst) begin
      if (!i_rst) begin
         r_state  <= ST_PAUSED;
         r_paused <= 1'b1;
         r_idx    <= '0;
         r_base   <= '0;
         r_tick   <= 1'b0;
      end else begin
         case (r_state)
            ST_PAUSED: begin
               if (r_run_s2) begin
                  r_state  <= ST_RUN;
                  r_paused <= 1'b0;
               end
            end
            ST_RUN: begin
               if (!r_run_s2) begin
                  r_state  <= ST_PAUSED;
                  r_paused <= 1'b1;
               end
            end
            default: begin
               r_state  <= ST_PAUSED;
               r_paused <= 1'b1;
            end
         endcase
         r_tick <= w_advance;
         if (w_advance) begin
            r_idx  <= w_idx_nxt;
            r_base <= w_base_nxt;
         end
      end
   end

   assign bus.frame_idx       = r_idx;
   assign bus.frame_base_addr = r_base;
   assign bus.frame_tick      = r_tick;
   assign bus.paused          = r_paused;

endmodule

// File: tb/tb_frame_sel_ctrl.sv
// Scoreboard bench for frame_sel_ctrl with a 4-frame, 8-sample, 4-cycle-debounce configuration.
module tb_frame_sel_ctrl;

   typedef struct {
      logic [1:0] idx;
      logic [4:0] base;
      int         cyc;
   } ev_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_pass;
   int   n_total;
   int   m_idx;
   ev_t  exp_q[$];
   ev_t  obs_q[$];

   frame_sel_if #(.FRAME_W(2), .ADDR_W(5)) bus ();

   frame_sel_ctrl #(
      .NUM_FRAMES(4), .FRAME_W(2), .FRAME_LEN(8), .ADDR_W(5), .DEBOUNCE_CYC(4)
   ) dut (
      .i_clk_in(clk),
      .i_rst   (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tick monitor sampling on the falling edge.
   always @(negedge clk) begin
      ev_t o;
      cyc = cyc + 1;
      if (bus.frame_tick === 1'b1) begin
         o.idx  = bus.frame_idx;
         o.base = bus.frame_base_addr;
         o.cyc  = cyc;
         obs_q.push_back(o);
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Model: advance the index and push the expected event; base from multiplication.
   task automatic expect_advance(input logic d, input int at_cyc);
      ev_t e;
      if (d == 1'b0) m_idx = (m_idx == 3) ? 0 : m_idx + 1;
      else           m_idx = (m_idx == 0) ? 3 : m_idx - 1;
      e.idx  = 2'(m_idx);
      e.base = 5'(m_idx * 8);
      e.cyc  = at_cyc;
      exp_q.push_back(e);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      bus.frame_clk = 1'b1; bus.run_en = 1'b1; bus.step_btn = 1'b0; bus.dir = 1'b0;
      m_idx = 0;
      wait_cyc(3);
      n_total++; if (bus.frame_idx !== 2'd0) $display("FAIL rst_idx got %0d want 0", bus.frame_idx); else n_pass++;
      n_total++; if (bus.frame_base_addr !== 5'd0) $display("FAIL rst_base got %0d want 0", bus.frame_base_addr); else n_pass++;
      n_total++; if (bus.frame_tick !== 1'b0) $display("FAIL rst_tick got %b want 0", bus.frame_tick); else n_pass++;
      n_total++; if (bus.paused !== 1'b1) $display("FAIL rst_paused got %b want 1", bus.paused); else n_pass++;
      rst = 1'b1;
      wait_cyc(2);
      n_total++; if (bus.paused !== 1'b1) $display("FAIL paused_early got %b want 1", bus.paused); else n_pass++;
      wait_cyc(1);
      n_total++; if (bus.paused !== 1'b0) $display("FAIL paused_run got %b want 0", bus.paused); else n_pass++;
      wait_cyc(10);
      n_total++; if (obs_q.size() != 0) $display("FAIL no_false_edge got %0d ticks want 0", obs_q.size()); else n_pass++;
      n_total++; if (bus.frame_idx !== 2'd0) $display("FAIL idx_after_rel got %0d want 0", bus.frame_idx); else n_pass++;
      obs_q.delete();
   endtask

   task automatic test_run_up;
      ev_t e, o;
      bus.frame_clk = 1'b0;
      wait_cyc(4);
      for (int k = 0; k < 5; k++) begin
         bus.frame_clk = 1'b1;
         expect_advance(1'b0, cyc + 4);
         wait_cyc(6);
         bus.frame_clk = 1'b0;
         wait_cyc(6);
      end
      n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL up_count got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_total++; if (o.idx !== e.idx) $display("FAIL up_idx got %0d want %0d", o.idx, e.idx); else n_pass++;
         n_total++; if (o.base !== e.base) $display("FAIL up_base got %0d want %0d", o.base, e.base); else n_pass++;
         n_total++; if (o.cyc != e.cyc) $display("FAIL up_latency got cyc %0d want %0d", o.cyc, e.cyc); else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_run_down;
      ev_t e, o;
      bus.dir = 1'b1;
      // bring index to 0 first: model is at 1 after the up test
      bus.frame_clk = 1'b1; expect_advance(1'b1, cyc + 4); wait_cyc(6);
      bus.frame_clk = 1'b0; wait_cyc(6);
      bus.frame_clk = 1'b1; expect_advance(1'b1, cyc + 4); wait_cyc(6);
      n_total++; if (obs_q.size() != 2) $display("FAIL dn_count got %0d want 2", obs_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_total++; if (o.idx !== e.idx) $display("FAIL dn_idx got %0d want %0d", o.idx, e.idx); else n_pass++;
         n_total++; if (o.base !== e.base) $display("FAIL dn_base got %0d want %0d", o.base, e.base); else n_pass++;
         n_total++; if (o.cyc != e.cyc) $display("FAIL dn_latency got cyc %0d want %0d", o.cyc, e.cyc); else n_pass++;
      end
      n_total++; if (bus.frame_idx !== 2'd3) $display("FAIL dn_wrap_idx got %0d want 3", bus.frame_idx); else n_pass++;
      n_total++; if (bus.frame_base_addr !== 5'd24) $display("FAIL dn_wrap_base got %0d want 24", bus.frame_base_addr); else n_pass++;
      bus.frame_clk = 1'b0;
      wait_cyc(8);
      n_total++; if (obs_q.size() != 0) $display("FAIL fall_edge got %0d ticks want 0", obs_q.size()); else n_pass++;
      bus.dir = 1'b0;
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_step_btn;
      ev_t e, o;
      bus.run_en = 1'b0;
      wait_cyc(5);
      n_total++; if (bus.paused !== 1'b1) $display("FAIL to_paused got %b want 1", bus.paused); else n_pass++;
      bus.step_btn = 1'b1; wait_cyc(3);
      bus.step_btn = 1'b0; wait_cyc(10);
      n_total++; if (obs_q.size() != 0) $display("FAIL glitch got %0d ticks want 0", obs_q.size()); else n_pass++;
      bus.step_btn = 1'b1;
      expect_advance(1'b0, -1);
      wait_cyc(10);
      bus.step_btn = 1'b0;
      wait_cyc(15);
      n_total++; if (obs_q.size() != 1) $display("FAIL press_count got %0d want 1", obs_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_total++; if (o.idx !== e.idx) $display("FAIL step_idx got %0d want %0d", o.idx, e.idx); else n_pass++;
         n_total++; if (o.base !== e.base) $display("FAIL step_base got %0d want %0d", o.base, e.base); else n_pass++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_dropped;
      for (int k = 0; k < 4; k++) begin
         bus.frame_clk = ~bus.frame_clk;
         wait_cyc(6);
      end
      n_total++; if (obs_q.size() != 0) $display("FAIL paused_fe got %0d ticks want 0", obs_q.size()); else n_pass++;
      bus.run_en = 1'b1;
      wait_cyc(5);
      n_total++; if (bus.paused !== 1'b0) $display("FAIL back_run got %b want 0", bus.paused); else n_pass++;
      bus.step_btn = 1'b1; wait_cyc(12);
      bus.step_btn = 1'b0; wait_cyc(12);
      n_total++; if (obs_q.size() != 0) $display("FAIL run_btn got %0d ticks want 0", obs_q.size()); else n_pass++;
      n_total++; if (bus.frame_idx !== 2'(m_idx)) $display("FAIL hold_idx got %0d want %0d", bus.frame_idx, m_idx); else n_pass++;
      obs_q.delete();
   endtask

   task automatic test_edge_cases;
      ev_t e, o;
      // run_en fall and frame_clk rise share the sync depth, so fe lands on the RUN->PAUSED cycle
      bus.run_en = 1'b0;
      bus.frame_clk = 1'b1;
      expect_advance(1'b0, cyc + 4);
      wait_cyc(8);
      n_total++; if (obs_q.size() != 1) $display("FAIL coinc_count got %0d want 1", obs_q.size()); else n_pass++;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_total++; if (o.idx !== e.idx) $display("FAIL coinc_idx got %0d want %0d", o.idx, e.idx); else n_pass++;
         n_total++; if (o.base !== e.base) $display("FAIL coinc_base got %0d want %0d", o.base, e.base); else n_pass++;
         n_total++; if (o.cyc != e.cyc) $display("FAIL coinc_latency got cyc %0d want %0d", o.cyc, e.cyc); else n_pass++;
      end
      n_total++; if (bus.paused !== 1'b1) $display("FAIL coinc_paused got %b want 1", bus.paused); else n_pass++;
      bus.frame_clk = 1'b0;
      bus.step_btn = 1'b1;
      wait_cyc(4);
      rst = 1'b0;
      #1;
      n_total++; if (bus.frame_idx !== 2'd0) $display("FAIL mid_rst_idx got %0d want 0", bus.frame_idx); else n_pass++;
      n_total++; if (bus.frame_base_addr !== 5'd0) $display("FAIL mid_rst_base got %0d want 0", bus.frame_base_addr); else n_pass++;
      n_total++; if (bus.frame_tick !== 1'b0) $display("FAIL mid_rst_tick got %b want 0", bus.frame_tick); else n_pass++;
      n_total++; if (bus.paused !== 1'b1) $display("FAIL mid_rst_paused got %b want 1", bus.paused); else n_pass++;
      wait_cyc(3);
      bus.step_btn = 1'b0;
      rst = 1'b1;
      m_idx = 0;
      wait_cyc(12);
      n_total++; if (obs_q.size() != 0) $display("FAIL post_rst got %0d ticks want 0", obs_q.size()); else n_pass++;
      n_total++; if (bus.frame_idx !== 2'd0) $display("FAIL post_rst_idx got %0d want 0", bus.frame_idx); else n_pass++;
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      cyc = 0; n_pass = 0; n_total = 0;
      test_reset();
      test_run_up();
      test_run_down();
      test_step_btn();
      test_dropped();
      test_edge_cases();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
